// File: rtl/sdram_pkg.sv
// sdram_pkg: shared arbiter states, SDRAM command encodings and address field widths
package sdram_pkg;
  typedef enum logic [3:0] {
    WAIT_INIT = 4'b0001,
    ARBIT     = 4'b0010,
    AREF      = 4'b0100,
    XFER      = 4'b1000
  } state_t;
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_MRS       = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam int BANK_W = 2;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 9;
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: client port bundle between requesters and the arbiter
interface sdram_port_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 24,
  parameter int LEN_W     = 9
);
  logic [NUM_PORTS-1:0]        port_req;
  logic [NUM_PORTS-1:0]        port_wr;
  logic [NUM_PORTS*ADDR_W-1:0] port_addr;
  logic [NUM_PORTS*LEN_W-1:0]  port_len;
  logic [NUM_PORTS-1:0]        port_gnt;
  logic [NUM_PORTS-1:0]        port_done;
  modport master (output port_req, port_wr, port_addr, port_len, input port_gnt, port_done);
  modport slave  (input port_req, port_wr, port_addr, port_len, output port_gnt, port_done);
endinterface

// File: rtl/sdram_rr_pick.sv
// sdram_rr_pick: first requester at or after ptr, wrapping at NUM_PORTS
module sdram_rr_pick import sdram_pkg::*; #(
  parameter int NUM_PORTS = 4,
  parameter int PW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PW-1:0]        idx,
  output logic                 any
);
  function automatic logic [PW-1:0] wrap(int v);
    return PW'((v >= NUM_PORTS) ? v - NUM_PORTS : v);
  endfunction
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (!any && req[wrap(int'(ptr) + i)]) begin
        any = 1'b1;
        idx = wrap(int'(ptr) + i);
      end
    if (any) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin burst scheduler with refresh priority for the SDRAM engines
module sdram_port_arbiter import sdram_pkg::*; #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 24,
  parameter int LEN_W     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_init_end,
  input  logic              aref_req,
  output logic              aref_en,
  input  logic              flag_aref_end,
  sdram_port_arbiter_if.slave ports,
  output logic              eng_wr_en,
  output logic              eng_rd_en,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [LEN_W-1:0]  eng_len,
  input  logic              eng_done,
  output logic              busy
);
  localparam int PW = $clog2(NUM_PORTS);
  state_t               state, state_n;
  logic [PW-1:0]        rr_ptr, ptr_n, win, win_n, idx;
  logic [NUM_PORTS-1:0] pick, gnt_n, done_n;
  logic                 any, aref_n, wr_n, rd_n, wr_sel;
  logic [ADDR_W-1:0]    addr_n, addr_sel;
  logic [LEN_W-1:0]     len_n, len_sel;
  function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
    return (p == PW'(NUM_PORTS - 1)) ? '0 : p + PW'(1);
  endfunction
  sdram_rr_pick #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_pick (
    .req (ports.port_req),
    .ptr (rr_ptr),
    .gnt (pick),
    .idx (idx),
    .any (any)
  );
  assign addr_sel = ports.port_addr[idx*ADDR_W +: ADDR_W];
  assign len_sel  = ports.port_len[idx*LEN_W +: LEN_W];
  assign wr_sel   = ports.port_wr[idx];
  assign busy     = state != ARBIT;
  always_comb begin
    state_n = state;
    ptr_n   = rr_ptr;
    win_n   = win;
    aref_n  = aref_en;
    gnt_n   = ports.port_gnt;
    done_n  = '0;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    addr_n  = eng_addr;
    len_n   = eng_len;
    case (state)
      WAIT_INIT: state_n = flag_init_end ? ARBIT : WAIT_INIT;
      ARBIT:
        if (aref_req) begin
          state_n = AREF;
          aref_n  = 1'b1;
        end else if (any && len_sel == '0) begin
          done_n = pick;
          ptr_n  = nxt(idx);
        end else if (any) begin
          state_n = XFER;
          win_n   = idx;
          gnt_n   = pick;
          addr_n  = addr_sel;
          len_n   = len_sel;
          wr_n    = wr_sel;
          rd_n    = !wr_sel;
        end
      AREF:
        if (flag_aref_end) begin
          state_n = ARBIT;
          aref_n  = 1'b0;
        end
      XFER:
        if (eng_done) begin
          state_n = ARBIT;
          done_n  = ports.port_gnt;
          gnt_n   = '0;
          ptr_n   = nxt(win);
        end
      default: state_n = WAIT_INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= WAIT_INIT;
      rr_ptr          <= '0;
      win             <= '0;
      aref_en         <= 1'b0;
      ports.port_gnt  <= '0;
      ports.port_done <= '0;
      eng_wr_en       <= 1'b0;
      eng_rd_en       <= 1'b0;
      eng_addr        <= '0;
      eng_len         <= '0;
    end else begin
      state           <= state_n;
      rr_ptr          <= ptr_n;
      win             <= win_n;
      aref_en         <= aref_n;
      ports.port_gnt  <= gnt_n;
      ports.port_done <= done_n;
      eng_wr_en       <= wr_n;
      eng_rd_en       <= rd_n;
      eng_addr        <= addr_n;
      eng_len         <= len_n;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed scoreboard bench for the SDRAM port arbiter
module tb_sdram_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 24;
  localparam int LW = 9;
  logic clk = 1'b0, rst_n = 1'b0, flag_init_end = 1'b0, aref_req = 1'b0;
  logic flag_aref_end = 1'b0, eng_done = 1'b0;
  logic aref_en, eng_wr_en, eng_rd_en, busy;
  logic [AW-1:0] eng_addr;
  logic [LW-1:0] eng_len;
  sdram_port_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .LEN_W(LW)) bus ();
  sdram_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flag_init_end (flag_init_end),
    .aref_req      (aref_req),
    .aref_en       (aref_en),
    .flag_aref_end (flag_aref_end),
    .ports         (bus),
    .eng_wr_en     (eng_wr_en),
    .eng_rd_en     (eng_rd_en),
    .eng_addr      (eng_addr),
    .eng_len       (eng_len),
    .eng_done      (eng_done),
    .busy          (busy)
  );
  always #10 clk = ~clk;
  typedef struct {
    int            p;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } exp_t;
  exp_t sb[$];
  int total = 0, fails = 0;
  function automatic logic [AW-1:0] addr_of(int p);
    return AW'(32'h123400 + p * 32'h111);
  endfunction
  function automatic logic [LW-1:0] len_of(int p);
    return LW'(p + 3);
  endfunction
  function automatic logic [31:0] oh(int p);
    return 32'(1) << p;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(int p);
    exp_t e;
    e.p    = p;
    e.wr   = bus.port_wr[p];
    e.addr = addr_of(p);
    e.len  = len_of(p);
    sb.push_back(e);
  endtask
  task automatic expect_grant(string tag);
    exp_t e;
    for (int i = 0; i < 20 && bus.port_gnt == '0; i++) tick();
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.p = N; e.wr = 1'b0; e.addr = '1; e.len = '1;
    end
    chk({tag, "_gnt"}, 32'(bus.port_gnt), oh(e.p));
    chk({tag, "_addr"}, 32'(eng_addr), 32'(e.addr));
    chk({tag, "_len"}, 32'(eng_len), 32'(e.len));
    chk({tag, "_start"}, 32'({eng_wr_en, eng_rd_en}), 32'({e.wr, !e.wr}));
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(1));
    chk({tag, "_aref_en"}, 32'(aref_en), 32'(0));
    chk({tag, "_gnt"}, 32'(bus.port_gnt), 32'(0));
    chk({tag, "_done"}, 32'(bus.port_done), 32'(0));
    chk({tag, "_start"}, 32'({eng_wr_en, eng_rd_en}), 32'(0));
    chk({tag, "_addr"}, 32'(eng_addr), 32'(0));
    chk({tag, "_len"}, 32'(eng_len), 32'(0));
    chk({tag, "_rr_ptr"}, 32'(dut.rr_ptr), 32'(0));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    bus.port_req = '0;
    bus.port_wr  = 4'b0101;
    for (int p = 0; p < N; p++) begin
      bus.port_addr[p*AW +: AW] = addr_of(p);
      bus.port_len[p*LW +: LW]  = len_of(p);
    end
    tick();
    tick();
    chk_reset("reset");
    rst_n = 1'b1;
    bus.port_req = 4'b1111;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("pre_init_gnt", 32'(bus.port_gnt), 32'(0));
      chk("pre_init_busy", 32'(busy), 32'(1));
    end
    for (int k = 0; k < 5; k++) push(k % N);
    flag_init_end = 1'b1;
    tick();
    flag_init_end = 1'b0;
    chk("init_arbit_gnt", 32'(bus.port_gnt), 32'(0));
    chk("init_arbit_busy", 32'(busy), 32'(0));
    tick();
    chk("init_p0_gnt", 32'(bus.port_gnt), oh(0));
    for (int k = 0; k < 5; k++) begin
      expect_grant($sformatf("rr%0d", k));
      if (k == 4) bus.port_req = '0;
      tick();
      chk("rr_pulse_once", 32'({eng_wr_en, eng_rd_en}), 32'(0));
      chk("rr_gnt_held", 32'(bus.port_gnt), oh(k % N));
      repeat (7) tick();
      chk("rr_addr_held", 32'(eng_addr), 32'(addr_of(k % N)));
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk("rr_done", 32'(bus.port_done), oh(k % N));
      chk("rr_gnt_clr", 32'(bus.port_gnt), 32'(0));
      tick();
      chk("rr_done_single", 32'(bus.port_done), 32'(0));
    end
    chk("idle_gnt", 32'(bus.port_gnt), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
    bus.port_req = 4'b0100;
    aref_req = 1'b1;
    push(2);
    tick();
    chk("aref_first_en", 32'(aref_en), 32'(1));
    chk("aref_first_gnt", 32'(bus.port_gnt), 32'(0));
    chk("aref_busy", 32'(busy), 32'(1));
    repeat (3) begin
      tick();
      chk("aref_held", 32'(aref_en), 32'(1));
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("spurious_eng_done", 32'(bus.port_done), 32'(0));
    chk("spurious_aref_held", 32'(aref_en), 32'(1));
    flag_aref_end = 1'b1;
    aref_req = 1'b0;
    tick();
    flag_aref_end = 1'b0;
    chk("aref_end_en", 32'(aref_en), 32'(0));
    chk("aref_end_gnt", 32'(bus.port_gnt), 32'(0));
    tick();
    expect_grant("aref_then_p2");
    bus.port_req = '0;
    tick();
    aref_req = 1'b1;
    repeat (3) begin
      tick();
      chk("xfer_aref_blocked", 32'(aref_en), 32'(0));
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("xfer_aref_done", 32'(bus.port_done), oh(2));
    chk("xfer_aref_still0", 32'(aref_en), 32'(0));
    tick();
    chk("xfer_aref_after", 32'(aref_en), 32'(1));
    chk("xfer_aref_nognt", 32'(bus.port_gnt), 32'(0));
    flag_aref_end = 1'b1;
    aref_req = 1'b0;
    tick();
    flag_aref_end = 1'b0;
    chk("xfer_aref_end", 32'(aref_en), 32'(0));
    bus.port_len[1*LW +: LW] = '0;
    bus.port_req = 4'b0010;
    tick();
    bus.port_req = '0;
    chk("zlen_done", 32'(bus.port_done), oh(1));
    chk("zlen_gnt", 32'(bus.port_gnt), 32'(0));
    chk("zlen_start", 32'({eng_wr_en, eng_rd_en}), 32'(0));
    tick();
    chk("zlen_done_single", 32'(bus.port_done), 32'(0));
    chk("zlen_rr_ptr", 32'(dut.rr_ptr), 32'(2));
    chk("zlen_busy", 32'(busy), 32'(0));
    bus.port_len[1*LW +: LW] = len_of(1);
    bus.port_req = 4'b1000;
    push(3);
    tick();
    expect_grant("p3");
    bus.port_req = '0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset("mid_xfer_reset");
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("post_rst_done", 32'(bus.port_done), 32'(0));
    chk("post_rst_busy", 32'(busy), 32'(1));
    bus.port_req = 4'b0001;
    repeat (3) tick();
    chk("post_rst_wait_init", 32'(bus.port_gnt), 32'(0));
    push(0);
    flag_init_end = 1'b1;
    tick();
    flag_init_end = 1'b0;
    tick();
    expect_grant("post_rst_p0");
    bus.port_req = '0;
    repeat (3) tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("post_rst_p0_done", 32'(bus.port_done), oh(0));
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
